// File: rtl/main_memory_pkg.sv
// Shared definitions for the main memory model and the cache that talks to it.
// Holds the FSM state encoding plus the default access latency and line size,
// so both sides agree on timing without duplicating constants.
package main_memory_pkg;

  // Memory controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_WRITE = 2'd3
  } mm_state_t;

  // Default access delay (cycles) and read line length (32-bit words)
  localparam int DEFAULT_LATENCY = 4;
  localparam int DEFAULT_BURST   = 4;

endpackage

// File: rtl/main_memory_mem_array.sv
// Word storage for main_memory: one combinational read port, one write port
// committed on the rising clock edge. Contents are deliberately not reset so
// that a controller reset never disturbs stored data.
module mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  // Synchronous write: the word takes its new value at the end of the cycle
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/main_memory.sv
// Main memory behind the cache: fixed-latency single-word writes, burst line reads.
// Latency: LATENCY cycles of WAIT after acceptance, then BURST beats (read) or one WRITE cycle.
// Backpressure: busy is high from the cycle after acceptance through done; req is only sampled in IDLE.
module main_memory
  import main_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = DEFAULT_LATENCY,
  parameter int BURST       = DEFAULT_BURST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        done
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Clears the low log2(BURST) bits of a word index to find the line base
  localparam logic [AW-1:0] LINE_MASK = ~AW'(BURST - 1);
  localparam logic [3:0]    LAST_BEAT = 4'(BURST - 1);
  localparam logic [3:0]    CNT_INIT  = 4'(LATENCY - 1);

  mm_state_t     state;
  logic [3:0]    cnt;
  logic [3:0]    beat;
  logic          lat_we;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;

  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic          wr_en;

  // Address bits outside the word index are intentionally dropped (modulo wrap)
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  assign rd_idx = (lat_idx & LINE_MASK) | AW'(beat);
  // A reset landing on the WRITE cycle aborts the store
  assign wr_en  = (state == ST_WRITE) && rst;
  assign rdata  = rvalid ? rd_word : 32'd0;

  mem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (lat_idx),
    .wr_data (lat_wdata),
    .rd_idx  (rd_idx),
    .rd_data (rd_word)
  );

  // Request FSM; busy/rvalid/done are registered alongside the state they describe
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      beat      <= 4'd0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
      busy      <= 1'b0;
      rvalid    <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rvalid <= 1'b0;
          done   <= 1'b0;
          beat   <= 4'd0;
          if (req) begin
            lat_we    <= we;
            lat_idx   <= addr[AW+1:2];
            lat_wdata <= wdata;
            cnt       <= CNT_INIT;
            busy      <= 1'b1;
            state     <= ST_WAIT;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            if (lat_we) begin
              done  <= 1'b1;
              state <= ST_WRITE;
            end else begin
              rvalid <= 1'b1;
              beat   <= 4'd0;
              done   <= (LAST_BEAT == 4'd0);
              state  <= ST_BURST;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_BURST: begin
          if (beat == LAST_BEAT) begin
            busy   <= 1'b0;
            rvalid <= 1'b0;
            done   <= 1'b0;
            beat   <= 4'd0;
            state  <= ST_IDLE;
          end else begin
            beat <= beat + 4'd1;
            done <= ((beat + 4'd1) == LAST_BEAT);
          end
        end
        ST_WRITE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// Randomized scoreboard bench for main_memory with default parameters.
// Driver pushes expected beats/done events; a negedge monitor pops and compares.
// Reference model is a flat word array indexed by (addr/4) mod DEPTH.
module tb_main_memory;

  localparam int DEPTH = 1024;
  localparam int LAT   = 4;
  localparam int BL    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        rvalid;
  logic [31:0] rdata;
  logic        done;

  main_memory #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BURST(BL)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .rvalid (rvalid),
    .rdata  (rdata),
    .done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          rv;
    logic [31:0] dat;
    bit          dn;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  int          exp_lo = 1;
  int          exp_hi = 0;
  bit          mon_on = 1'b0;
  bit          stop = 1'b0;
  bit          fin = 1'b0;
  int          total = 0;
  int          bad = 0;

  // Monitor: busy window, idle rdata, and ordered beat/done events
  always @(negedge clk) begin
    if (mon_on && !fin) begin
      exp_t e;
      bit   exp_busy;
      exp_busy = (cyc >= exp_lo) && (cyc <= exp_hi);
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
      end
      if (rvalid !== 1'b1) begin
        total++;
        if (rdata !== 32'd0) begin
          bad++;
          $display("FAIL idle_rdata cyc=%0d got=%h want=00000000", cyc, rdata);
        end
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL missing_event due_cyc=%0d now=%0d want_rv=%b want_dat=%h", e.cyc, cyc, e.rv, e.dat);
      end
      if (rvalid === 1'b1 || done === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event cyc=%0d rvalid=%b done=%b rdata=%h", cyc, rvalid, done, rdata);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.rv !== rvalid || e.dn !== done || (e.rv && rdata !== e.dat)) begin
            bad++;
            $display("FAIL event cyc=%0d got rv=%b dn=%b dat=%h; want cyc=%0d rv=%b dn=%b dat=%h",
                     cyc, rvalid, done, rdata, e.cyc, e.rv, e.dn, e.dat);
          end
        end
      end
      if (stop) begin
        total++;
        if (sb.size() != 0) begin
          bad++;
          $display("FAIL leftover_events got=%0d want=0", sb.size());
        end
        fin = 1'b1;
      end
    end
  end

  task automatic wait_until(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Issue one request in the current (idle) cycle. hold: 0 drop req,
  // 1 keep req high with random fields while busy, 2 keep req high unchanged.
  task automatic do_txn(input bit w, input logic [31:0] a, input logic [31:0] d, input int hold);
    int c;
    int idx;
    int base;
    int end_c;
    exp_t e;
    c     = cyc;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    idx   = int'((a >> 2) % DEPTH);
    base  = (idx / BL) * BL;
    end_c = c + LAT + (w ? 1 : BL);
    exp_lo = c + 1;
    exp_hi = end_c;
    if (w) begin
      model_mem[idx] = d;
      e = '{cyc: end_c, rv: 1'b0, dat: 32'd0, dn: 1'b1};
      sb.push_back(e);
    end else begin
      for (int i = 0; i < BL; i++) begin
        e = '{cyc: c + LAT + 1 + i, rv: 1'b1, dat: model_mem[base + i], dn: (i == BL - 1)};
        sb.push_back(e);
      end
    end
    @(negedge clk);
    if (hold == 0) begin
      req = 1'b0;
    end else if (hold == 1) begin
      while (cyc <= end_c) begin
        req   = 1'b1;
        we    = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        @(negedge clk);
      end
    end
    wait_until(end_c + 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cyc=%0d limit_reached", cyc);
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [31:0] a;
    int          c;
    // Reset with req asserted: must not be accepted
    rst = 1'b0;
    req = 1'b1;
    we  = 1'b1;
    addr = 32'h40;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);

    // Preload words 0..63
    for (int i = 0; i < 64; i++) do_txn(1'b1, 32'(i * 4), $urandom, 0);

    // Line read at 0x40 after writing A,B,C,D
    do_txn(1'b1, 32'h40, 32'hAAAA_0001, 0);
    do_txn(1'b1, 32'h44, 32'hBBBB_0002, 0);
    do_txn(1'b1, 32'h48, 32'hCCCC_0003, 0);
    do_txn(1'b1, 32'h4C, 32'hDDDD_0004, 0);
    do_txn(1'b0, 32'h40, 32'd0, 0);

    // Write then immediate read of the same line
    do_txn(1'b1, 32'h44, 32'hDEAD_BEEF, 0);
    do_txn(1'b0, 32'h4C, 32'd0, 0);

    // Re-pulsed req during a read, then back-to-back held reads
    do_txn(1'b0, 32'h80, 32'd0, 1);
    do_txn(1'b0, 32'h90, 32'd0, 2);
    do_txn(1'b0, 32'h90, 32'd0, 0);

    // Address wrap and ignored byte offset
    do_txn(1'b1, 32'h1000, 32'h1234_5678, 0);
    do_txn(1'b0, 32'h0, 32'd0, 0);
    do_txn(1'b1, 32'h1003, 32'h8765_4321, 0);
    do_txn(1'b0, 32'h0, 32'd0, 0);

    // Reset in cycle 3 of a write to 0x10: aborted, location unchanged
    c = cyc;
    req = 1'b1;
    we = 1'b1;
    addr = 32'h10;
    wdata = 32'hBAD0_BAD0;
    exp_lo = c + 1;
    exp_hi = c + LAT + 1;
    @(negedge clk);
    req = 1'b0;
    wait_until(c + 3);
    rst = 1'b0;
    req = 1'b1;
    wdata = 32'hBAD1_BAD1;
    exp_hi = c + 3;
    @(negedge clk);
    rst = 1'b1;
    do_txn(1'b0, 32'h10, 32'd0, 0);

    // Randomized mix over preloaded words with random high address bits
    for (int i = 0; i < 60; i++) begin
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      do_txn(1'($urandom), a, $urandom, (i == 59) ? 0 : int'($urandom_range(0, 2)));
    end

    req = 1'b0;
    repeat (3) @(negedge clk);
    stop = 1'b1;
    for (int k = 0; k < 10 && !fin; k++) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage size in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 4, access delay in cycles (legal range 1..15).
REQ-003 SHALL have parameter BURST, default 4, words per read line (power of two, 1..8).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-006 SHALL have port req  in  1  request strobe from the cache miss/write-through path.
REQ-007 SHALL have port we  in  1  1 = single-word write, 0 = line read; qualified by req.
REQ-008 SHALL have port addr  in  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port wdata  in  32  write data; qualified by req & we.
REQ-010 SHALL have port busy  out  1  request in progress; requester holds off.
REQ-011 SHALL have port rvalid  out  1  rdata carries one read beat this cycle.
REQ-012 SHALL have port rdata  out  32  read beat data.
REQ-013 SHALL have port done  out  1  one-cycle pulse on the final cycle of any request.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, BURST, WRITE.
REQ-015 SHALL sample req only in IDLE; on req=1, latch we, addr, wdata and go to WAIT with the latency counter at LATENCY-1.
REQ-016 SHALL ignore req in every state other than IDLE; latched fields SHALL NOT change while busy.
REQ-017 SHALL drive busy=1 in every non-IDLE state (cycle 1 to the done cycle inclusive, with the request accepted in cycle 0).
REQ-018 WAIT SHALL decrement the counter each cycle; at zero, SHALL go to BURST if we=0, else to WRITE.
REQ-019 For a read, beat i (0..BURST-1) SHALL appear in cycle LATENCY+1+i, with rvalid=1 and rdata=mem[line_base+i], where line_base is the word index with its low log2(BURST) bits cleared.
REQ-020 For a read, done SHALL be 1 together with the last beat; the next state SHALL be IDLE.
REQ-021 For a write, WRITE SHALL last one cycle (cycle LATENCY+1) with done=1; mem[word index] SHALL take wdata at the end of that cycle; the next state SHALL be IDLE.
REQ-022 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (modulo wrap).
REQ-023 rdata SHALL be 0 whenever rvalid=0.
REQ-024 A req held high SHALL be accepted in the first IDLE cycle after done, so back-to-back requests have no gap cycle beyond IDLE.
REQ-025 A read of a location in the cycle after that location's write done SHALL return the new data.

Reset
REQ-026 rst=0 at a clock edge SHALL force IDLE, clear the counter, beat index and latched fields, and drive busy=0, rvalid=0, rdata=0, done=0 in the following cycle, including during a request.
REQ-027 Reset SHALL NOT modify the memory array; an aborted write SHALL leave its location unchanged.
REQ-028 req SHALL be ignored in any cycle where rst=0.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding and the default LATENCY and BURST constants, which the cache also uses.
REQ-030 The storage array SHALL be one sub-module, mem_array (1 read port, 1 synchronous write port), instantiated by main_memory.

Verification
REQ-031 Reset, then read addr=0x40 with mem[16..19]=A,B,C,D -> rvalid in cycles 5..8, rdata A,B,C,D, done in cycle 8, busy in cycles 1..8.
REQ-032 Write addr=0x44, wdata=0xDEADBEEF, then read addr=0x4C -> done in cycle 5; read beat 1 = 0xDEADBEEF.
REQ-033 req pulsed again in cycles 2 and 3 of a read -> ignored; exactly 4 beats and one done.
REQ-034 Write addr=0x1000 with DEPTH_WORDS=1024 -> mem[0] updated (wrap); addr[1:0]=2'b11 gives the same result.
REQ-035 rst=0 in cycle 3 of a write to 0x10 -> busy/done/rvalid=0 next cycle, FSM IDLE, mem[4] unchanged.
REQ-036 req held high across two reads -> second accepted in the first IDLE cycle after the first done; no lost or duplicated beats.
